// File: rtl/memoria_dados_ctrl_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// byte-enable patterns and size/alignment helpers.
package memoria_dados_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic {
    OCIOSO  = 1'b0,
    SEGUNDA = 1'b1
  } estado_t;

  function automatic logic [3:0] tamanho_bytes(input logic [2:0] f3);
    logic [3:0] tam;
    case (f3[1:0])
      2'b00:   tam = 4'd1;
      2'b01:   tam = 4'd2;
      2'b10:   tam = 4'd4;
      default: tam = 4'd8;
    endcase
    return tam;
  endfunction

  // 111 has no defined size, so it is reported as misaligned.
  function automatic logic alinhado(input logic [2:0] f3, input logic [2:0] addr);
    logic [3:0] mascara;
    mascara = tamanho_bytes(f3) - 4'd1;
    return (f3 != 3'b111) && ((addr & mascara[2:0]) == 3'b000);
  endfunction

  function automatic logic [3:0] be_base(input logic [2:0] f3);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_B;
      2'b01:   be = BE_H;
      default: be = BE_W;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/memoria_dados_ctrl_extrai_carga.sv
// Picks the addressed lane out of a 32-bit word and sign- or zero-extends it
// to 64 bits according to funct3.
module extrai_carga
  import memoria_dados_ctrl_pkg::*;
(
  input  logic [31:0] palavra,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] dado
);

  logic [31:0] desloc;

  always_comb begin
    desloc = palavra >> {addr, 3'b000};
    dado   = '0;
    case (funct3[1:0])
      2'b00:   dado = funct3[2] ? {56'd0, desloc[7:0]}  : {{56{desloc[7]}}, desloc[7:0]};
      2'b01:   dado = funct3[2] ? {48'd0, desloc[15:0]} : {{48{desloc[15]}}, desloc[15:0]};
      2'b10:   dado = funct3[2] ? {32'd0, desloc}       : {{32{desloc[31]}}, desloc};
      default: dado = {32'd0, desloc};
    endcase
  end

endmodule

// File: rtl/memoria_dados_ctrl.sv
// Data-memory responder: 32-bit byte-enabled array, single-beat B/H/W and
// two-beat D accesses with a pronto/ocupado handshake.
//
// state   | meaning
// OCIOSO  | idle; accepts a request, B/H/W and misaligned complete from here
// SEGUNDA | second (high-word) beat of a D access; new requests ignored
module memoria_dados_ctrl
  import memoria_dados_ctrl_pkg::*;
#(
  parameter int PROF_PALAVRAS = 1024,
  parameter int LARG_IDX      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WeDM,
  input  logic [2:0]  funct3,
  input  logic [63:0] endereco,
  input  logic [63:0] dinDM,
  output logic [63:0] doutDM,
  output logic        pronto,
  output logic        ocupado,
  output logic        erro_alinhamento
);

  estado_t             estado_q, estado_d;
  logic [LARG_IDX-1:0] idx_q, idx_d;
  logic                we_q, we_d;
  logic [31:0]         alto_q, alto_d;
  logic [31:0]         baixo_q, baixo_d;
  logic [63:0]         dout_q, dout_d;
  logic                pronto_q, pronto_d;
  logic                erro_q, erro_d;

  logic [31:0]         mem [PROF_PALAVRAS];
  logic [LARG_IDX-1:0] idx_req;
  logic [LARG_IDX-1:0] mem_idx;
  logic                mem_we;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;
  logic [63:0]         carga_ext;
  logic                ok_alinh;
  logic                sinal_unused;

  // Address bits above the index only alias; the array wraps.
  assign sinal_unused = ^endereco[63:LARG_IDX+2];
  assign idx_req      = endereco[LARG_IDX+1:2];
  assign ok_alinh     = alinhado(funct3, endereco[2:0]);
  assign mem_rdata    = mem[mem_idx];

  extrai_carga u_extrai_carga (
    .palavra (mem_rdata),
    .addr    (endereco[1:0]),
    .funct3  (funct3),
    .dado    (carga_ext)
  );

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    we_d      = we_q;
    alto_d    = alto_q;
    baixo_d   = baixo_q;
    dout_d    = dout_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;
    mem_idx   = idx_req;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;

    if (estado_q == OCIOSO) begin
      if (req) begin
        if (!ok_alinh) begin
          pronto_d = 1'b1;
          erro_d   = 1'b1;
        end else if (funct3[1:0] == 2'b11) begin
          mem_we    = WeDM;
          mem_be    = BE_W;
          mem_wdata = dinDM[31:0];
          idx_d     = idx_req;
          we_d      = WeDM;
          alto_d    = dinDM[63:32];
          baixo_d   = mem_rdata;
          estado_d  = SEGUNDA;
        end else begin
          mem_we   = WeDM;
          mem_be   = be_base(funct3) << endereco[1:0];
          pronto_d = 1'b1;
          case (funct3[1:0])
            2'b00:   mem_wdata = {4{dinDM[7:0]}};
            2'b01:   mem_wdata = {2{dinDM[15:0]}};
            default: mem_wdata = dinDM[31:0];
          endcase
          if (!WeDM) dout_d = carga_ext;
        end
      end
    end else begin
      // High word lives at the odd index; store data comes from the accept-time latch.
      mem_idx   = {idx_q[LARG_IDX-1:1], 1'b1};
      mem_we    = we_q;
      mem_be    = BE_W;
      mem_wdata = alto_q;
      pronto_d  = 1'b1;
      estado_d  = OCIOSO;
      if (!we_q) dout_d = {mem_rdata, baixo_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      idx_q    <= '0;
      we_q     <= 1'b0;
      alto_q   <= '0;
      baixo_q  <= '0;
      dout_q   <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      alto_q   <= alto_d;
      baixo_q  <= baixo_d;
      dout_q   <= dout_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

  // Writes are suppressed by reset so an aborted D store never lands its high word.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign doutDM           = dout_q;
  assign pronto           = pronto_q;
  assign ocupado          = (estado_q == SEGUNDA);
  assign erro_alinhamento = erro_q;

endmodule

// File: doc/memoria_dados_ctrl.md
Name: memoria_dados_ctrl

Overview:
- Responder (memory end) of the processor's data-memory interface.
- Accepts load/store requests addressed by the ALU result (doutULA), with store data from dinDM and access size/sign taken from funct3.
- Returns load data on doutDM.
- Backing store is a 32-bit-wide byte-enabled array, so 64-bit accesses take two array beats; a busy/done handshake covers the variable latency.

Parameters:
- PROF_PALAVRAS, 1024, depth of the backing array in 32-bit words; must be even.
- LARG_IDX, 10, width of the word index, equal to log2(PROF_PALAVRAS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req  input  1  request valid; sampled only when ocupado=0.
- WeDM  input  1  1=store, 0=load; qualified by req.
- funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is treated as misaligned.
- endereco  input  64  byte address (doutULA).
- dinDM  input  64  store data, least-significant bytes used for sub-double sizes.
- doutDM  output  64  load data, sign- or zero-extended.
- pronto  output  1  one-cycle pulse: request complete, doutDM/erro valid.
- ocupado  output  1  high while the second beat of a D access is in progress.
- erro_alinhamento  output  1  valid with pronto: access was misaligned, no memory effect.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to OCIOSO; doutDM=0, pronto=0, ocupado=0, erro_alinhamento=0.
  - Array contents are not cleared.
  - Reset during SEGUNDA aborts the access: a D store leaves its low word written and its high word untouched; no pronto is issued.
- Word index is endereco[LARG_IDX+1:2]; higher address bits are ignored, so addresses wrap modulo 4*PROF_PALAVRAS bytes.
- Alignment:
  - H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
  - A misaligned request performs no array read or write. Next cycle: pronto=1, erro_alinhamento=1, doutDM unchanged.
- FSM states: OCIOSO, SEGUNDA.
- OCIOSO with req=1, aligned, size B/H/W:
  - Store: in the accept cycle, write the byte lanes selected by addr[1:0]/size from dinDM[7:0]/[15:0]/[31:0].
  - Load: read the word, extract the lane by addr[1:0], then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to 64 bits.
  - Next cycle: pronto=1 and doutDM valid (load latency 1). State stays OCIOSO.
- OCIOSO with req=1, aligned, size D:
  - Beat 0 (accept cycle): access the even word (low half, dinDM[31:0] / data[31:0]).
  - Latch the index and the request, then go to SEGUNDA; ocupado=1.
- SEGUNDA:
  - Beat 1: access index+1 (high half, dinDM[63:32]).
  - Return to OCIOSO; pronto=1 on the following cycle. Total D latency is 2 cycles.
  - Store data for beat 1 is taken from the value latched at accept, not from the live dinDM.
- req while ocupado=1 is ignored; the requester holds req until ocupado=0.
- Throughput and overlap:
  - A new request may be accepted in the same cycle pronto is high, giving back-to-back B/H/W at 1 request/cycle.
  - A load following a store to the same address returns the stored data; writes complete in their beat cycle.
- Output hold rules:
  - pronto is a registered single-cycle pulse.
  - doutDM holds its value until the next load completes.
  - After a store, pronto=1 and doutDM is unchanged.
  - erro_alinhamento is 0 whenever pronto=0.

Decomposition:
- Shared package:
  - funct3 codes (F3_LB..F3_LWU).
  - Size decode function (funct3[1:0] → 1/2/4/8 bytes).
  - FSM state enum {OCIOSO, SEGUNDA}.
  - Byte-enable generation constants.
- One natural sub-module: extrai_carga, a combinational block with inputs word[31:0], addr[1:0], funct3, and output the 64-bit extended result.
  - For D loads, the top level concatenates the beat-1 word over the latched beat-0 word instead.

Test Plan:
- SD 0x1122334455667788 to addr 0x10; then LD addr 0x10:
  - Store: ocupado=1 for 1 cycle, pronto 2 cycles after accept.
  - Load: doutDM=0x1122334455667788, pronto 2 cycles after accept.
- SB 0x80 at addr 0x13:
  - LB 0x13 → doutDM=0xFFFFFFFFFFFFFF80.
  - LBU 0x13 → 0x0000000000000080.
  - LW 0x10 → 0xFFFFFFFF80000000; the other three bytes of that word must be unchanged from a prior SW 0x00000000.
- Back-to-back LW 0x0, LW 0x4, LW 0x8 with req held 3 cycles → three consecutive pronto pulses with correct data; ocupado stays 0.
- LD addr 0x14 and LH addr 0x11 → pronto=1, erro_alinhamento=1 one cycle later; a subsequent LD 0x10 shows memory unchanged.
- SD to addr 0x20 with reset=0 asserted in the SEGUNDA cycle:
  - After reset, LW 0x20 returns the low half and LW 0x24 returns the old value.
  - pronto never pulses for the aborted store, and all outputs are 0 after reset.
- Address wrap (PROF_PALAVRAS=1024): SW to 0x1008 then LW 0x0008 → same data; req asserted during ocupado is ignored and produces no extra pronto.
